// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO family.
package fifo_pkg;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_DEPTH  = 16;

  // The occupancy counter needs one more bit than the pointers so it can hold DEPTH.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// One-write/one-read register-array storage.
// The write is synchronous and the read is asynchronous, so either read mode can be built on top.
module fifo_ram_dp #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with thresholds, an occupancy count, an optional FWFT read mode,
// a flush input and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        winc,
  input  logic [DWIDTH-1:0]           wdata,
  input  logic                        rinc,
  input  logic                        flush,
  input  logic                        clr_err,
  output logic [DWIDTH-1:0]           rdata,
  output logic                        rvalid,
  output logic                        wfull,
  output logic                        afull,
  output logic                        rempty,
  output logic                        aempty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  if (DWIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_param
    $fatal(1, "sync_fifo_param: illegal parameter combination");
  end

  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d, ram_rdata;
  logic              rvalid_q, rvalid_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              rd_ok, wr_ok;

  // Handshake: a read is accepted when rinc is high and the FIFO holds data; a write is accepted
  // when winc is high and there is room, or room is being made by an accepted read in the same cycle.
  // Rejected requests set the sticky error flags; rdata is meaningful only while rvalid is high.
  assign rd_ok = rinc && (count_q != '0);
  assign wr_ok = winc && ((count_q != CW'(DEPTH)) || rd_ok);

  fifo_ram_dp #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok && !flush && !rst),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + AW'(1);
      if (rd_ok) begin
        rptr_d   = rptr_q + AW'(1);
        rdata_d  = ram_rdata;
        rvalid_d = 1'b1;
      end
      if (wr_ok && !rd_ok) count_d = count_q + CW'(1);
      if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
      if (winc && !wr_ok) ovf_d = 1'b1;
      if (rinc && !rd_ok) unf_d = 1'b1;
    end
    // Clearing wins over a new error in the same cycle.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign count     = count_q;
  assign wfull     = (count_q == CW'(DEPTH));
  assign afull     = (count_q >= CW'(AFULL_TH));
  assign rempty    = (count_q == '0);
  assign aempty    = (count_q <= CW'(AEMPTY_TH));
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign rdata     = FWFT ? ram_rdata : rdata_q;
  assign rvalid    = FWFT ? !rempty : rvalid_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's 16x8 dual-clock FIFO1.
- Generalises data width and depth.
- Adds parametrised almost-full/almost-empty thresholds, an occupancy count, a selectable first-word-fall-through (FWFT) read mode, synchronous flush, and sticky overflow/underflow error flags.
- Used as a same-domain elastic buffer between pipeline stages.

Parameters:
- DWIDTH, 8, data width in bits (>=1).
- DEPTH, 16, number of entries; power of 2, >=4.
- AFULL_TH, DEPTH-2, afull asserted when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 2, aempty asserted when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- winc, in, 1, write request.
- wdata, in, DWIDTH, write data, sampled when the write is accepted.
- rinc, in, 1, read request (FWFT=1: pop/acknowledge of the current head).
- flush, in, 1, synchronous flush: empties the FIFO.
- clr_err, in, 1, clears overflow and underflow.
- rdata, out, DWIDTH, read data.
- rvalid, out, 1, rdata holds valid data.
- wfull, out, 1, count == DEPTH.
- afull, out, 1, count >= AFULL_TH.
- rempty, out, 1, count == 0.
- aempty, out, 1, count <= AEMPTY_TH.
- count, out, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
- overflow, out, 1, sticky: a write was rejected.
- underflow, out, 1, sticky: a read was rejected.

Behaviour:
- Reset: synchronous, active-high (rst sampled on the rising clk edge).
  - Pointers = 0, count = 0, rdata = 0, rvalid = 0, overflow = underflow = 0.
  - Consequent flags: rempty = 1, aempty = 1, wfull = 0, afull = 0.
  - Storage array is not reset.
  - rst mid-operation discards all contents in that cycle; winc/rinc in that cycle are ignored.
- Pointers: wptr/rptr are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. Occupancy is tracked by the separate count register.
- Read acceptance: rd_ok = rinc && count != 0.
  - On an empty FIFO a simultaneous write does not satisfy a read in the same cycle (no bypass).
- Write acceptance: wr_ok = winc && (count != DEPTH || rd_ok).
  - When full, a write is accepted only together with an accepted read.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged on both or neither.
- Flags: all status flags are decoded from the count register, so they reflect the new occupancy the cycle after the operation.
- FWFT=0 (registered read):
  - On rd_ok, rdata <= mem[rptr] and rvalid <= 1 at the next edge (1-cycle latency).
  - Otherwise rvalid <= 0 and rdata holds its last value.
- FWFT=1 (first-word-fall-through):
  - rdata = mem[rptr], combinational from registered state.
  - rvalid = !rempty.
  - The first written word appears on rdata the cycle after its write.
  - rd_ok advances to the next entry.
- Errors (sticky until clr_err or rst; clr_err has priority over a new set in the same cycle):
  - overflow <= 1 when winc && !wr_ok.
  - underflow <= 1 when rinc && !rd_ok.
- flush:
  - Priority: rst > flush > normal operation.
  - Pointers and count go to 0 and rvalid goes to 0; winc/rinc in the flush cycle are ignored.
  - Error flags and rdata are not cleared.
- Parameter legality is checked at elaboration; an illegal value stops elaboration with a fatal error.

Decomposition:
- Shared package fifo_pkg holds the default DWIDTH/DEPTH constants and a function for the count width (clog2(DEPTH)+1).
- One sub-module, fifo_ram_dp: 1-write/1-read register-array memory.
  - Synchronous write.
  - Asynchronous read port, so the top level can build both read modes.
- Control (pointers, count, flags, errors) stays in the top level.

Test Plan (DWIDTH=8, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2):
- Fill/drain, FWFT=0:
  - Write 0x01..0x10 -> count reaches 16, wfull=1.
  - afull=1 from count=14; aempty=0 from count=3.
  - Read 16 -> data 0x01..0x10 in order, each rvalid 1 cycle after rinc; rempty=1 at end.
- Overflow/underflow:
  - At full, winc=1 -> count stays 16, overflow=1.
  - Drain, then rinc on empty -> underflow=1.
  - clr_err -> both flags 0.
- Simultaneous read+write:
  - At count=16 -> write accepted, count stays 16, no overflow.
  - At count=0 -> read rejected, count=1, underflow=1.
- Wrap-around: 40 interleaved writes/reads keeping count 3..5 -> data integrity across pointer wrap, no flags set.
- FWFT=1:
  - Write 0xA5 -> next cycle rdata=0xA5, rvalid=1 with no rinc.
  - rinc -> rvalid=0, rempty=1.
- Flush/reset mid-operation:
  - At count=9 with winc=rinc=1, assert flush -> next cycle count=0, rempty=1, pending ops dropped.
  - Same scenario with rst -> additionally overflow=0, underflow=0, rdata=0.
